// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM port arbiter.
// Requester IDs are one bit wide; the in-flight record tracks the single
// access whose response is due in the next cycle.
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
    } inflight_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way grant.
// With RAM_ARB_ROUND_ROBIN_EN defined, contention goes to the requester that
// did not win last time; otherwise requester 0 always wins contention.
module rr_arbiter2 (
    input  logic valid_0,
    input  logic valid_1,
`ifdef RAM_ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_any,
    output logic grant_id
);

    // Pick at most one winner from the two pending requests.
    always_comb begin
        grant_any = valid_0 | valid_1;
        grant_id  = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (valid_0 && valid_1) begin
            grant_id = ~last_grant;
        end else if (valid_1) begin
            grant_id = 1'b1;
        end
`else
        if (!valid_0 && valid_1) begin
            grant_id = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two requesters sharing one single-port RAM with 1-cycle read latency.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (round-robin contention;
// when undefined requester 0 has fixed priority and last_grant is absent).
//
// Handshake: a request transfers on the rising edge where req_valid_n_i and
// req_ready_n_o are both 1. ready is combinational and high only for the
// granted requester; the requester holds addr/wdata/write stable while valid
// is high and not yet accepted. Every accepted request returns exactly one
// rsp_valid_n_o strobe in the following cycle, with no backpressure.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WORD   = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid_0_i,
    output logic              req_ready_0_o,
    input  logic [ADDR_W-1:0] req_addr_0_i,
    input  logic [WORD-1:0]   req_wdata_0_i,
    input  logic              req_write_0_i,
    output logic              rsp_valid_0_o,
    output logic [WORD-1:0]   rsp_rdata_0_o,

    input  logic              req_valid_1_i,
    output logic              req_ready_1_o,
    input  logic [ADDR_W-1:0] req_addr_1_i,
    input  logic [WORD-1:0]   req_wdata_1_i,
    input  logic              req_write_1_i,
    output logic              rsp_valid_1_o,
    output logic [WORD-1:0]   rsp_rdata_1_o,

    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [WORD-1:0]   ram_data_o,
    output logic              ram_write_o,
    input  logic [WORD-1:0]   ram_data_i
);

    logic      arb_valid_0;
    logic      arb_valid_1;
    logic      grant_any;
    req_id_t   grant_id;
    inflight_t inflight;

    // Requests are invisible to the arbiter while reset is held.
    assign arb_valid_0 = req_valid_0_i & ~rst;
    assign arb_valid_1 = req_valid_1_i & ~rst;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    req_id_t last_grant;

    rr_arbiter2 u_arb (
        .valid_0    (arb_valid_0),
        .valid_1    (arb_valid_1),
        .last_grant (last_grant),
        .grant_any  (grant_any),
        .grant_id   (grant_id)
    );

    // Remember the most recent winner; reset to 1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_any) begin
            last_grant <= grant_id;
        end
    end
`else
    rr_arbiter2 u_arb (
        .valid_0    (arb_valid_0),
        .valid_1    (arb_valid_1),
        .grant_any  (grant_any),
        .grant_id   (grant_id)
    );
`endif

    assign req_ready_0_o = grant_any & (grant_id == 1'b0);
    assign req_ready_1_o = grant_any & (grant_id == 1'b1);

    // Steer the granted request onto the RAM port; idle port drives zeros.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_data_o  = '0;
        ram_write_o = 1'b0;
        if (grant_any) begin
            ram_en_o = 1'b1;
            if (grant_id == 1'b0) begin
                ram_addr_o  = req_addr_0_i;
                ram_data_o  = req_wdata_0_i;
                ram_write_o = req_write_0_i;
            end else begin
                ram_addr_o  = req_addr_1_i;
                ram_data_o  = req_wdata_1_i;
                ram_write_o = req_write_1_i;
            end
        end
    end

    // One-deep in-flight record: overwritten every cycle, so grants can
    // issue back to back while the previous response drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            inflight <= '{valid: grant_any, owner: grant_id};
        end
    end

    // Response strobes; reset squashes a pending response immediately.
    assign rsp_valid_0_o = inflight.valid & (inflight.owner == 1'b0) & ~rst;
    assign rsp_valid_1_o = inflight.valid & (inflight.owner == 1'b1) & ~rst;
    assign rsp_rdata_0_o = rsp_valid_0_o ? ram_data_i : '0;
    assign rsp_rdata_1_o = rsp_valid_1_o ? ram_data_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered RAM.
// Unwritten RAM words read as 0x1000 + address.
module tb_ram_port_arbiter;

    localparam int WORD   = 16;
    localparam int ADDR_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              valid0, valid1, write0, write1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [WORD-1:0]   wdata0, wdata1;
    logic              ready0, ready1, rsp_v0, rsp_v1;
    logic [WORD-1:0]   rsp_d0, rsp_d1;
    logic              ram_en, ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD-1:0]   ram_wdata;
    logic [WORD-1:0]   ram_rdata;

    ram_port_arbiter #(.WORD(WORD), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_0_i (valid0),
        .req_ready_0_o (ready0),
        .req_addr_0_i  (addr0),
        .req_wdata_0_i (wdata0),
        .req_write_0_i (write0),
        .rsp_valid_0_o (rsp_v0),
        .rsp_rdata_0_o (rsp_d0),
        .req_valid_1_i (valid1),
        .req_ready_1_o (ready1),
        .req_addr_1_i  (addr1),
        .req_wdata_1_i (wdata1),
        .req_write_1_i (write1),
        .rsp_valid_1_o (rsp_v1),
        .rsp_rdata_1_o (rsp_d1),
        .ram_en_o      (ram_en),
        .ram_addr_o    (ram_addr),
        .ram_data_o    (ram_wdata),
        .ram_write_o   (ram_write),
        .ram_data_i    (ram_rdata)
    );

    // ---------------- RAM model (read-first, 1-cycle latency) ----------------
    logic [WORD-1:0] model_mem [256];
    logic            model_wr  [256];
    logic            model_clr = 1'b1;

    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < 256; i++) model_wr[i] <= 1'b0;
        end else if (ram_en) begin
            ram_rdata <= model_wr[ram_addr] ? model_mem[ram_addr]
                                            : (16'h1000 + {8'h00, ram_addr});
            if (ram_write) begin
                model_mem[ram_addr] <= ram_wdata;
                model_wr[ram_addr]  <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    int cnt0 = 0;
    int cnt1 = 0;
    logic            pend_v0 = 1'b0, pend_v1 = 1'b0;
    logic [WORD-1:0] pend_d0 = '0,   pend_d1 = '0;
    logic [WORD-1:0] sh_mem [256];
    logic            sh_wr  [256];
    logic [3:0]      g_tab;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD-1:0] exp_word(input logic [ADDR_W-1:0] a);
        return sh_wr[a] ? sh_mem[a] : (16'h1000 + {8'h00, a});
    endfunction

    // One clock cycle: inputs already applied; e0/e1 are the expected grants.
    task automatic do_cycle(input logic e0, input logic e1);
        logic [ADDR_W-1:0] ga;
        logic [WORD-1:0]   gd;
        logic              gw;
        #1;
        chk("ready0", 32'(ready0), 32'(e0));
        chk("ready1", 32'(ready1), 32'(e1));
        chk("ram_en", 32'(ram_en), 32'(e0 | e1));
        if (e0) begin
            ga = addr0; gd = wdata0; gw = write0;
        end else if (e1) begin
            ga = addr1; gd = wdata1; gw = write1;
        end else begin
            ga = '0; gd = '0; gw = 1'b0;
        end
        chk("ram_addr",  32'(ram_addr),  32'(ga));
        chk("ram_data",  32'(ram_wdata), 32'(gd));
        chk("ram_write", 32'(ram_write), 32'(gw));
        chk("rsp_valid0", 32'(rsp_v0), 32'(pend_v0));
        chk("rsp_valid1", 32'(rsp_v1), 32'(pend_v1));
        chk("rsp_rdata0", 32'(rsp_d0), 32'(pend_v0 ? pend_d0 : 16'h0000));
        chk("rsp_rdata1", 32'(rsp_d1), 32'(pend_v1 ? pend_d1 : 16'h0000));
        cnt0 += int'(rsp_v0);
        cnt1 += int'(rsp_v1);
        pend_v0 = e0;
        pend_v1 = e1;
        if (e0) begin
            pend_d0 = exp_word(addr0);
            if (write0) begin sh_mem[addr0] = wdata0; sh_wr[addr0] = 1'b1; end
        end
        if (e1) begin
            pend_d1 = exp_word(addr1);
            if (write1) begin sh_mem[addr1] = wdata1; sh_wr[addr1] = 1'b1; end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin sh_wr[i] = 1'b0; sh_mem[i] = '0; end
`ifdef RAM_ARB_ROUND_ROBIN_EN
        g_tab = 4'b1010;
`else
        g_tab = 4'b0000;
`endif
        valid0 = 1'b1; addr0 = 8'h20; wdata0 = '0; write0 = 1'b0;
        valid1 = 1'b1; addr1 = 8'h30; wdata1 = '0; write1 = 1'b0;
        @(posedge clk);
        #1;
        model_clr = 1'b0;

        // Reset with both valid: everything quiet.
        do_cycle(1'b0, 1'b0);
        do_cycle(1'b0, 1'b0);
        rst = 1'b0;

        // Contention: four cycles with both requesters reading.
        for (int i = 0; i < 4; i++) begin
            do_cycle(!g_tab[i], g_tab[i]);
            if (!g_tab[i]) addr0 = addr0 + 8'd1;
            else           addr1 = addr1 + 8'd1;
        end
        valid0 = 1'b0; valid1 = 1'b0;
        do_cycle(1'b0, 1'b0);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        chk("contention_cnt0", 32'(cnt0), 32'd2);
        chk("contention_cnt1", 32'(cnt1), 32'd2);
`else
        chk("contention_cnt0", 32'(cnt0), 32'd4);
        chk("contention_cnt1", 32'(cnt1), 32'd0);
`endif

        // Write 0xBEEF at 0x10 from requester 0, then read it from requester 1.
        valid0 = 1'b1; addr0 = 8'h10; wdata0 = 16'hBEEF; write0 = 1'b1;
        do_cycle(1'b1, 1'b0);
        valid0 = 1'b0; write0 = 1'b0; wdata0 = '0;
        valid1 = 1'b1; addr1 = 8'h10;
        do_cycle(1'b0, 1'b1);
        valid1 = 1'b0;
        chk("wr_rd_value", 32'(rsp_d1), 32'h0000BEEF);
        do_cycle(1'b0, 1'b0);

        // Requester 1 streams 8 reads with no bubble.
        cnt1 = 0;
        valid1 = 1'b1; addr1 = 8'h40;
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 1'b1);
            addr1 = addr1 + 8'd1;
        end
        valid1 = 1'b0;
        do_cycle(1'b0, 1'b0);
        chk("stream_cnt1", 32'(cnt1), 32'd8);

        // Reset in the cycle after an accepted read squashes its response.
        valid0 = 1'b1; addr0 = 8'h50;
        do_cycle(1'b1, 1'b0);
        valid0 = 1'b0;
        rst = 1'b1;
        pend_v0 = 1'b0;
        do_cycle(1'b0, 1'b0);
        rst = 1'b0;
        do_cycle(1'b0, 1'b0);
        // last_grant back to 1: requester 0 wins the first contention.
        valid0 = 1'b1; addr0 = 8'h60;
        valid1 = 1'b1; addr1 = 8'h70;
        do_cycle(1'b1, 1'b0);
        addr0 = 8'h61;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        do_cycle(1'b0, 1'b1);
        addr1 = 8'h71;
`else
        do_cycle(1'b1, 1'b0);
        addr0 = 8'h62;
`endif

        // Four more cycles of continuous contention.
        for (int i = 0; i < 4; i++) begin
            do_cycle(!g_tab[i], g_tab[i]);
            if (!g_tab[i]) addr0 = addr0 + 8'd1;
            else           addr1 = addr1 + 8'd1;
        end
        valid0 = 1'b0; valid1 = 1'b0;
        do_cycle(1'b0, 1'b0);
        do_cycle(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter: WORD, default 16, data width in bits.
REQ-002 Parameter: ADDR_W, default 8, address width in bits.
REQ-003 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-004 Ports SHALL be, per requester n in {0,1} (one per line: name, direction, width, meaning):
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 req_valid_n_i  in  1  request pending
 req_ready_n_o  out  1  request accepted this cycle
 req_addr_n_i  in  ADDR_W  word address
 req_wdata_n_i  in  WORD  write data
 req_write_n_i  in  1  1 = write, 0 = read
 rsp_valid_n_o  out  1  response strobe
 rsp_rdata_n_o  out  WORD  read data
 ram_en_o  out  1  RAM port enable
 ram_addr_o  out  ADDR_W  RAM address
 ram_data_o  out  WORD  RAM write data
 ram_write_o  out  1  RAM write strobe
 ram_data_i  in  WORD  RAM registered read data, 1-cycle latency

Function
REQ-005 The block SHALL multiplex two requesters onto one single-port RAM access port, granting at most one request per cycle.
REQ-006 A request SHALL be accepted on the rising edge where req_valid_n_i and req_ready_n_o are both 1; req_ready_n_o SHALL be combinational and high only for the granted requester.
REQ-007 Arbitration SHALL be round-robin: if both are valid, the requester not in register last_grant wins; if only one is valid, it wins.
REQ-008 last_grant SHALL update on each accepted request only.
REQ-009 ram_en_o, ram_addr_o, ram_data_o and ram_write_o SHALL be driven combinationally from the granted request; with no grant, ram_en_o = 0, ram_write_o = 0, and address/data = 0.
REQ-010 Each accepted request (read or write) SHALL produce exactly one rsp_valid_n_o pulse to the same requester in the cycle after acceptance (latency 1).
REQ-011 rsp_rdata_n_o SHALL equal ram_data_i while rsp_valid_n_o = 1 and 0 otherwise; for writes it carries the pre-write word.
REQ-012 In-flight tracking SHALL be a registered valid bit plus an owner-ID bit; back-to-back grants every cycle SHALL be supported with no bubble.
REQ-013 Responses SHALL have no backpressure; the requester must consume the response in its strobe cycle.
REQ-014 Requests from the same requester SHALL be answered in order; the block SHALL never reorder or drop an accepted request.

Reset
REQ-015 While rst = 1: req_ready_n_o = 0, ram_en_o = 0, ram_write_o = 0, rsp_valid_n_o = 0, rsp_rdata_n_o = 0, and last_grant = 1, so requester 0 wins the first contention.
REQ-016 Reset asserted with a response pending SHALL squash it: no rsp_valid pulse in the cycle after reset.

Configuration
REQ-017 Macro RAM_ARB_ROUND_ROBIN_EN: when defined, arbitration SHALL follow REQ-007; when undefined, requester 0 SHALL always win contention and last_grant SHALL be removed.

Structure
REQ-018 A shared package ram_arb_pkg SHALL hold the requester-ID typedef (1-bit), the in-flight record typedef (valid, owner), and the NUM_REQ = 2 constant.
REQ-019 One sub-module, rr_arbiter2 (combinational two-way grant with a last_grant input), is natural; the rest stays in ram_port_arbiter.

Verification
REQ-020 Reset: rst = 1 with both requesters valid -> all outputs 0; after release, both valid on the same cycle -> requester 0 granted first.
REQ-021 Contention: both requesters issue 4 reads continuously -> grants alternate 0,1,0,1 and each requester receives exactly 2 rsp_valid pulses with correct data.
REQ-022 Write then read: requester 0 writes 0xBEEF at 0x10, then requester 1 reads 0x10 -> rsp_rdata_1_o = 0xBEEF, one cycle after acceptance.
REQ-023 Single requester streaming: requester 1 alone issues 8 reads in consecutive cycles -> ready held high, 8 consecutive responses, no bubble.
REQ-024 Reset mid-flight: rst asserted in the cycle after a read is accepted -> no response pulse, and last_grant = 1 afterwards.
REQ-025 Macro undefined: both requesters valid for 4 cycles -> requester 0 granted in all 4 cycles, requester 1 never ready.
